// File: rtl/serialin_panel.sv
// serialin_panel
//   Board-side responder for the three-wire panel serial link. It oversamples
//   sclk / sdata / sdata_pl on the system clock. It deserialises the host's
//   LED byte (LSB first) into a latched parallel output. It serialises a
//   snapshot of the button inputs back on sdatain.
//
//   Ports:
//     clk, rst_n         system clock, async active-low reset
//     sclk, sdata        link shift clock (gated) and host data
//     sdata_pl           frame strobe, high for the whole frame
//     sdatain            return data to host (flop output, tx_sr[0])
//     pin[WIDTH]         asynchronous button inputs
//     pout[WIDTH]        latched received byte
//     pout_valid         1-cycle pulse when pout updates
//     frame_err          1-cycle pulse when a frame ends with count != WIDTH
//
//   Build option: define SERIALIN_DEBOUNCE_EN to debounce each pin bit with a
//   per-bit counter (DEBOUNCE_CYCLES consecutive equal samples). When the
//   macro is undefined, pin is only double-synchronised.

`ifdef SERIALIN_DEBOUNCE_EN
// One debounced input bit. The output follows d only after d has differed
// from the output for DEBOUNCE_CYCLES consecutive samples.
module serialin_panel_db_bit #(
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          q_q, q_d;

  always_comb begin
    cnt_d = '0;
    q_d   = q_q;
    if (d != q_q) begin
      if (cnt_q == LAST) q_d   = d;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end

  assign q = q_q;
endmodule
`endif

module serialin_panel #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             sdata,
  input  logic             sdata_pl,
  output logic             sdatain,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  output logic             frame_err
);
  localparam int            CW       = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_SAT  = CW'(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  // ---------------------------------------------------------------- link sync
  // Lane packing: bit 0 sclk, bit 1 sdata, bit 2 sdata_pl. sync_q[0] is first.
  logic [SYNC_STAGES-1:0][2:0] sync_q, sync_d;
  logic [2:0]                  line_s;
  logic [1:0]                  dly_q, dly_d;    // {pl, sclk} one cycle older
  logic                        sclk_s, sdata_s, pl_s;
  logic                        sclk_rise, pl_rise, pl_fall;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], {sdata_pl, sdata, sclk}};
  end

  assign line_s    = sync_q[SYNC_STAGES-1];
  assign sclk_s    = line_s[0];
  assign sdata_s   = line_s[1];
  assign pl_s      = line_s[2];
  assign dly_d     = {pl_s, sclk_s};
  assign sclk_rise = sclk_s & ~dly_q[0];
  assign pl_rise   = pl_s & ~dly_q[1];
  assign pl_fall   = ~pl_s & dly_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= '0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  // ---------------------------------------------------------------- pin path
  logic [WIDTH-1:0] pin_m_q, pin_s_q;
  logic [WIDTH-1:0] pin_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin_m_q <= '0;
      pin_s_q <= '0;
    end else begin
      pin_m_q <= pin;
      pin_s_q <= pin_m_q;
    end
  end

`ifdef SERIALIN_DEBOUNCE_EN
  serialin_panel_db_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [WIDTH-1:0] (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pin_s_q),
    .q     (pin_load)
  );
`else
  assign pin_load = pin_s_q;
  // Debounce window has no meaning in this build.
  if (DEBOUNCE_CYCLES < 1) begin : g_db_unused
  end
`endif

  // ---------------------------------------------------------------- frame FSM
  state_t           state_q, state_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pout_q, pout_d;
  logic             pv_q, pv_d;
  logic             fe_q, fe_d;
  logic             shift_en;

  always_comb begin
    state_d  = state_q;
    rx_d     = rx_q;
    tx_d     = tx_q;
    cnt_d    = cnt_q;
    pout_d   = pout_q;
    pv_d     = 1'b0;
    fe_d     = 1'b0;
    shift_en = 1'b0;

    case (state_q)
      IDLE: begin
        // Keep reloading so tx_sr[0] is already valid when the host samples
        // the first bit; the reload stops on the frame-start cycle.
        cnt_d = '0;
        tx_d  = pin_load;
        if (pl_rise) begin
          state_d  = SHIFT;
          tx_d     = tx_q;
          shift_en = sclk_rise;   // coincident first edge still counts
        end
      end
      SHIFT: begin
        // An edge landing with the strobe's fall is dropped (pl_s already low).
        if (pl_fall)                 state_d  = LATCH;
        else if (sclk_rise && pl_s)  shift_en = 1'b1;
      end
      LATCH: begin
        state_d = IDLE;
        if (cnt_q == CNT_FULL) begin
          pout_d = rx_q;
          pv_d   = 1'b1;
        end else begin
          fe_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (shift_en) begin
      rx_d  = {sdata_s, rx_q[WIDTH-1:1]};
      tx_d  = {1'b0, tx_q[WIDTH-1:1]};
      // Saturating so an over-long frame can never wrap back to WIDTH.
      cnt_d = (cnt_d == CNT_SAT) ? cnt_d : cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rx_q    <= '0;
      tx_q    <= '0;
      cnt_q   <= '0;
      pout_q  <= '0;
      pv_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      pout_q  <= pout_d;
      pv_q    <= pv_d;
      fe_q    <= fe_d;
    end
  end

  assign sdatain    = tx_q[0];
  assign pout       = pout_q;
  assign pout_valid = pv_q;
  assign frame_err  = fe_q;
endmodule

// File: tb/tb_serialin_panel.sv
// Scoreboard bench for serialin_panel. The host task drives frames on the
// pins and pushes what the block must answer: one event per frame (latched
// byte or error) and one return bit per host sclk rise. Two monitors pop and
// compare as the DUT presents pulses and as the host samples sdatain.
module tb_serialin_panel;
  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         sclk = 1'b0, sdata = 1'b0, sdata_pl = 1'b0;
  logic         sdatain;
  logic [W-1:0] pin = '0, pout;
  logic         pout_valid, frame_err;

  always #5 clk = ~clk;

  serialin_panel #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sclk       (sclk),
    .sdata      (sdata),
    .sdata_pl   (sdata_pl),
    .sdatain    (sdatain),
    .pin        (pin),
    .pout       (pout),
    .pout_valid (pout_valid),
    .frame_err  (frame_err)
  );

  typedef struct {
    bit           is_err;
    logic [W-1:0] pout;
  } ev_t;

  ev_t          evq[$];
  bit           txq[$];
  int           checks = 0, passes = 0;
  logic [W-1:0] model_pout = '0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Frame-end monitor.
  always @(negedge clk) begin : mon_ev
    ev_t e;
    if (rst_n && (pout_valid || frame_err)) begin
      chk("pulse_exclusive", {31'b0, pout_valid & frame_err}, 32'd0);
      if (evq.size() == 0) begin
        chk("unexpected_event", {30'b0, pout_valid, frame_err}, 32'd0);
      end else begin
        e = evq.pop_front();
        chk("event_is_err", {31'b0, frame_err}, {31'b0, e.is_err});
        chk("pout", {24'b0, pout}, {24'b0, e.pout});
      end
    end
  end

  // Return-data monitor: the host samples sdatain on its own sclk rise.
  always @(posedge sclk) begin : mon_tx
    bit b;
    if (txq.size() > 0) begin
      b = txq.pop_front();
      chk("sdatain", {31'b0, sdatain}, {31'b0, b});
    end
  end

  // One host frame. The snapshot is the pin value present at frame start;
  // the host reads snap[k] on its k-th rise, and zeros once the register
  // has been shifted out. Exactly WIDTH edges latch data, anything else is an
  // error that leaves pout alone.
  task automatic frame(input logic [W-1:0] pv, input logic [W-1:0] data,
                       input int nedges, input int hp, input bit tight,
                       input int rst_after, input bit chg,
                       input logic [W-1:0] newpin, input bit glitch);
    int           seen;
    bit           chk_tx;
    logic [W-1:0] snap;
    ev_t          e;
    pin = pv;
    cyc(40);
    if (glitch) begin
      pin[0] = ~pv[0]; cyc(20); pin[0] = pv[0];
    end
    cyc(40);
    snap   = pv;
    chk_tx = 1'b1;
    seen   = nedges;
    sdata  = data[0];
    cyc(hp);
    sdata_pl = 1'b1;
    if (!tight) cyc(hp);
    for (int k = 0; k < nedges; k++) begin
      if (k > 0) begin
        sdata = (k < W) ? data[k] : 1'($urandom);
        cyc(hp);
      end
      if (chg && k == 4) pin = newpin;
      if (chk_tx) txq.push_back((k < W) ? snap[k] : 1'b0);
      sclk = 1'b1;
      cyc(hp);
      sclk = 1'b0;
      if (k == rst_after) begin
        cyc(3);
        rst_n = 1'b0;
        cyc(1);
        chk("rst_sdatain", {31'b0, sdatain}, 32'd0);
        chk("rst_pout", {24'b0, pout}, 32'd0);
        chk("rst_pout_valid", {31'b0, pout_valid}, 32'd0);
        chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
        cyc(2);
        rst_n      = 1'b1;
        model_pout = '0;
        chk_tx     = 1'b0;
        seen       = nedges - k - 1;
      end
    end
    cyc(hp);
    sdata_pl = 1'b0;
    if (seen == W) begin
      e.is_err = 1'b0; e.pout = data; model_pout = data;
    end else begin
      e.is_err = 1'b1; e.pout = model_pout;
    end
    evq.push_back(e);
    cyc(12);
  endtask

  initial begin
    cyc(2);
    chk("reset_sdatain", {31'b0, sdatain}, 32'd0);
    chk("reset_pout", {24'b0, pout}, 32'd0);
    chk("reset_pout_valid", {31'b0, pout_valid}, 32'd0);
    chk("reset_frame_err", {31'b0, frame_err}, 32'd0);
    rst_n = 1'b1;
    cyc(5);

    // Nominal.
    frame(8'hA5, 8'h3C, W, 16, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    // Short frame, then the counter must be back at zero.
    frame(8'h5A, 8'h77, 5, 16, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    chk("cnt_idle", 32'(dut.cnt_q), 32'd0);
    // Long frame, then a clean one.
    frame(8'h33, 8'hFF, 10, 16, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    frame(8'hC3, 8'h01, W, 16, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    // Snapshot freeze, then the new value comes back next frame.
    frame(8'h0F, 8'h96, W, 16, 1'b0, -1, 1'b1, 8'hF0, 1'b0);
    frame(8'hF0, 8'h69, W, 16, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    // Reset after edge 3: remaining edges form a short frame.
    frame(8'h12, 8'hE7, W, 16, 1'b0, 3, 1'b0, 8'h00, 1'b0);
    frame(8'h48, 8'h81, W, 16, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    // First sclk rise coincident with the strobe rise.
    frame(8'hB2, 8'h4D, W, 16, 1'b1, -1, 1'b0, 8'h00, 1'b0);
`ifdef SERIALIN_DEBOUNCE_EN
    frame(8'h00, 8'h11, W, 16, 1'b0, -1, 1'b0, 8'h00, 1'b1);
    frame(8'h01, 8'h22, W, 16, 1'b0, -1, 1'b0, 8'h00, 1'b0);
`endif

    for (int i = 0; i < 25; i++) begin
      logic [W-1:0] pv, dv, np;
      int           ne;
      pv = W'($urandom);
      dv = W'($urandom);
      np = W'($urandom);
      ne = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 11)) : W;
      frame(pv, dv, ne, int'($urandom_range(S + 4, 20)),
            ($urandom_range(0, 4) == 0), -1, 1'($urandom), np, 1'b0);
    end

    for (int i = 0; i < 200 && evq.size() > 0; i++) cyc(1);
    chk("events_drained", 32'(evq.size()), 32'd0);
    chk("tx_drained", 32'(txq.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
